lc3_mem_interface: RTL and testbench

- MAR/MDR memory-interface stage of the LC-3 datapath, sitting directly upstream of the 16-bit tri-state buffer that gates MDR onto the shared bus (GateMDR path).
- Loads MAR/MDR from the bus and runs a multi-cycle read/write handshake with external memory.
- Returns the LC-3 ready signal R to the control unit.
- Supplies the MDR value and the gate enable that drive the downstream tri-state buffer.

---
 rtl/lc3_pkg.sv | 20 ++
 rtl/mem_timeout_ctr.sv | 30 +++
 rtl/lc3_mem_interface.sv | 113 +++++++++++
 tb/tb_lc3_mem_interface.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc3_pkg : shared types and constants for the LC-3 MAR/MDR interface  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lc3_pkg;

  localparam int DATA_W = 16;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_timeout_ctr : 8-bit wait counter, expires at TIMEOUT-1           |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // Expiry is seen during the TIMEOUT-th waiting cycle, so REQ lasts TIMEOUT cycles.
  assign expire = (count == 8'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/lc3_mem_interface.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc3_mem_interface : LC-3 MAR/MDR stage with memory handshake FSM     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lc3_mem_interface
  import lc3_pkg::*;
#(
  parameter int DATA_W  = lc3_pkg::DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] busIn,
  input  logic              ldMAR,
  input  logic              ldMDR,
  input  logic              mioEn,
  input  logic              rw,
  input  logic              gateMDR,
  output logic [DATA_W-1:0] mdrOut,
  output logic              mdrGateEn,
  output logic              ready,
  output logic              memReq,
  output logic              memWe,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memAck,
  output logic              memErr
);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              wr_latched;
  logic              mem_err;
  logic              expire;
  logic              access_start;

  assign access_start = (state == IDLE) && mioEn;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (access_start),
    .enable ((state == REQ) && !memAck),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    memReq   = 1'b0;
    memWe    = 1'b0;
    ready    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mioEn) state_nx = REQ;
      end
      REQ: begin
        memReq = 1'b1;
        memWe  = (wr_latched == RW_WRITE);
        if (memAck || expire) state_nx = DONE;
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // MAR/MDR only accept bus loads while idle; during an access they are frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      mar        <= '0;
      mdr        <= '0;
      wr_latched <= RW_READ;
      mem_err    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (ldMAR) mar <= busIn;
        if (ldMDR && !mioEn) mdr <= busIn;
        if (mioEn) wr_latched <= rw;
      end
      if (state == REQ) begin
        if (memAck) begin
          if ((wr_latched == RW_READ) && ldMDR) mdr <= memRData;
        end else if (expire) begin
          mem_err <= 1'b1;
        end
      end
    end
  end

  assign mdrOut    = mdr;
  assign memWData  = mdr;
  assign memAddr   = mar;
  assign memErr    = mem_err;
  assign mdrGateEn = gateMDR;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_interface.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_lc3_mem_interface : scoreboard bench for lc3_mem_interface        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lc3_mem_interface;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] busIn = '0;
  logic        ldMAR = 1'b0;
  logic        ldMDR = 1'b0;
  logic        mioEn = 1'b0;
  logic        rw = 1'b0;
  logic        gateMDR = 1'b0;
  logic [15:0] memRData = '0;
  logic        memAck = 1'b0;
  logic [15:0] mdrOut;
  logic        mdrGateEn;
  logic        ready;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic        memErr;

  lc3_mem_interface #(
    .DATA_W  (16),
    .TIMEOUT (T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .busIn     (busIn),
    .ldMAR     (ldMAR),
    .ldMDR     (ldMDR),
    .mioEn     (mioEn),
    .rw        (rw),
    .gateMDR   (gateMDR),
    .mdrOut    (mdrOut),
    .mdrGateEn (mdrGateEn),
    .ready     (ready),
    .memReq    (memReq),
    .memWe     (memWe),
    .memAddr   (memAddr),
    .memWData  (memWData),
    .memRData  (memRData),
    .memAck    (memAck),
    .memErr    (memErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdr;
    logic        we;
    logic        err;
    int          n;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          req_cnt = 0;
  logic [15:0] m_mdr = '0;
  logic        m_err = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Each step moves to just after the next rising edge and puts idle defaults on the inputs.
  task automatic step();
    @(posedge clk);
    #1;
    ldMAR    = 1'b0;
    ldMDR    = 1'b0;
    mioEn    = 1'b0;
    memAck   = 1'($urandom);
    memRData = 16'($urandom);
    busIn    = 16'($urandom);
    rw       = 1'($urandom);
    gateMDR  = 1'($urandom);
  endtask

  // One complete access from IDLE; ack_at > T means memory never answers.
  task automatic access(input logic [15:0] addr, input logic [15:0] wd, input logic wr,
                        input logic set_mdr, input logic ld, input int ack_at,
                        input logic [15:0] rd);
    exp_t e;
    int   n;
    step();
    if (set_mdr) begin
      busIn = wd;
      ldMDR = 1'b1;
      m_mdr = wd;
    end
    step();
    busIn = addr;
    ldMAR = 1'b1;
    ldMDR = 1'($urandom);
    mioEn = 1'b1;
    rw    = wr;
    n       = (ack_at <= T) ? ack_at : T;
    e.addr  = addr;
    e.wdata = m_mdr;
    e.we    = wr;
    e.n     = n;
    if (ack_at <= T) begin
      if (!wr && ld) m_mdr = rd;
    end else begin
      m_err = 1'b1;
    end
    e.mdr = m_mdr;
    e.err = m_err;
    sb.push_back(e);
    for (int i = 1; i <= n; i++) begin
      step();
      busIn    = 16'($urandom);
      ldMAR    = 1'($urandom);
      mioEn    = 1'($urandom);
      memAck   = (i == ack_at);
      memRData = (i == ack_at) ? rd : 16'($urandom);
      ldMDR    = (i == ack_at) ? ld : 1'($urandom);
    end
    step();
    mioEn = 1'($urandom);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      check("gate_en", {31'd0, mdrGateEn}, {31'd0, gateMDR});
      if (rst) begin
        req_cnt = 0;
      end else begin
        if (memReq) begin
          if (sb.size() == 0) begin
            check("req_unexpected", {31'd0, memReq}, 32'd0);
          end else begin
            req_cnt++;
            check("req_addr", {16'd0, memAddr}, {16'd0, sb[0].addr});
            check("req_wdata", {16'd0, memWData}, {16'd0, sb[0].wdata});
            check("req_we", {31'd0, memWe}, {31'd0, sb[0].we});
          end
        end
        if (ready) begin
          if (sb.size() == 0) begin
            check("ready_unexpected", {31'd0, ready}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("req_cycles", req_cnt, e.n);
            check("done_mdr", {16'd0, mdrOut}, {16'd0, e.mdr});
            check("done_err", {31'd0, memErr}, {31'd0, e.err});
            check("done_req_low", {31'd0, memReq}, 32'd0);
            req_cnt = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    exp_t e;
    repeat (3) step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mdr", {16'd0, mdrOut}, 32'd0);
    check("rst_mar", {16'd0, memAddr}, 32'd0);
    check("rst_req", {31'd0, memReq}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_we", {31'd0, memWe}, 32'd0);
    check("rst_err", {31'd0, memErr}, 32'd0);
    step();
    rst = 1'b0;

    // Bus load of MDR followed by gating it toward the bus.
    step();
    busIn = 16'h1234;
    ldMDR = 1'b1;
    m_mdr = 16'h1234;
    step();
    gateMDR = 1'b1;
    @(negedge clk);
    check("bus_mdr", {16'd0, mdrOut}, 32'h1234);
    check("bus_gate", {31'd0, mdrGateEn}, 32'd1);
    check("bus_no_req", {31'd0, memReq}, 32'd0);

    access(16'h3000, 16'h0000, 1'b0, 1'b0, 1'b1, 3, 16'hBEEF);
    access(16'h4001, 16'h00AA, 1'b1, 1'b1, 1'b1, 2, 16'h5555);
    access(16'h5000, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 16'hC0DE);
    access(16'h5001, 16'h0000, 1'b0, 1'b0, 1'b1, T + 3, 16'hDEAD);
    access(16'h5002, 16'h0000, 1'b0, 1'b0, 1'b1, 2, 16'h1357);
    access(16'h5003, 16'h0000, 1'b0, 1'b0, 1'b0, T, 16'h2468);

    // Reset asserted during the second REQ cycle of a read.
    step();
    busIn = 16'h6000;
    ldMAR = 1'b1;
    mioEn = 1'b1;
    rw    = 1'b0;
    e.addr = 16'h6000; e.wdata = m_mdr; e.we = 1'b0; e.mdr = m_mdr; e.err = m_err; e.n = 0;
    sb.push_back(e);
    step();
    memAck = 1'b0;
    step();
    memAck = 1'b0;
    rst    = 1'b1;
    sb.delete();
    m_mdr = '0;
    m_err = 1'b0;
    step();
    rst    = 1'b0;
    memAck = 1'b1;
    @(negedge clk);
    check("midrst_req", {31'd0, memReq}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_mar", {16'd0, memAddr}, 32'd0);
    check("midrst_mdr", {16'd0, mdrOut}, 32'd0);
    check("midrst_err", {31'd0, memErr}, 32'd0);
    repeat (3) begin
      step();
      memAck = 1'b1;
    end

    for (int k = 0; k < 40; k++) begin
      access(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(1, T + 2)), 16'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (4) step();
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
